pipe_rca_adder: RTL and testbench

//   Parametrised, pipelined ripple-carry adder/subtractor built from chained full-adder cells.

---
 rtl/adder_pkg.sv | 17 +
 rtl/rca_chunk.sv | 32 +++
 rtl/pipe_rca_adder.sv | 144 ++++++++++++++
 tb/tb_pipe_rca_adder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared sizing helpers for the pipelined ripple-carry adder family.
// Consumers import adder_pkg::* and derive their stage count from WIDTH/CHUNK.
package adder_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CHUNK = 4;

    function automatic int calc_stages(input int width, input int chunk);
        return width / chunk;
    endfunction

    // The slicing only works when every stage sees a full chunk.
    function automatic bit width_ok(input int width, input int chunk);
        return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/rca_chunk.sv
// Purpose: N-bit ripple of full-adder cells, one pipeline slice of the adder.
// Latency: combinational, zero cycles.
// Backpressure: none; the enclosing pipeline decides when results are captured.
module rca_chunk
    import adder_pkg::*;
#(
    parameter int N = DEF_CHUNK
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co,
    output logic         c_msb_in
);

    logic [N:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < N; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co       = c[N];
    assign c_msb_in = c[N - 1];

endmodule

// File: rtl/pipe_rca_adder.sv
// Purpose: pipelined WIDTH-bit add/sub, one CHUNK-bit ripple slice per stage (ovf port under ADDER_OVF_FLAG_EN).
// Latency: WIDTH/CHUNK cycles from accept to out_valid, throughput one beat per cycle.
// Backpressure: whole pipe freezes while out_valid & ~out_ready; in_ready = ~stall.
module pipe_rca_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef ADDER_OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int STAGES = calc_stages(WIDTH, CHUNK);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sub;
        logic             cin;
    } beat_t;

    if (!width_ok(WIDTH, CHUNK)) begin : g_bad_cfg
        $error("pipe_rca_adder: WIDTH must be a non-zero multiple of CHUNK");
    end

    logic              stall;
    logic [STAGES-1:0] vld_q, vld_d;
    beat_t             beat_q [STAGES];
    beat_t             beat_d [STAGES];
    logic [WIDTH-1:0]  sum_q  [STAGES];
    logic [WIDTH-1:0]  sum_d  [STAGES];

    logic [STAGES-1:0] src_vld;
    beat_t             src_beat [STAGES];
    logic [WIDTH-1:0]  src_sum  [STAGES];
    logic [CHUNK-1:0]  ch_a     [STAGES];
    logic [CHUNK-1:0]  ch_b     [STAGES];
    logic [CHUNK-1:0]  ch_s     [STAGES];
    logic              ch_ci    [STAGES];
    logic              ch_co    [STAGES];
    logic              ch_cmsb  [STAGES];

    assign stall    = vld_q[STAGES-1] & ~out_ready;
    assign in_ready = ~stall;

    // Stage inputs: stage 0 takes the port beat, stage k takes the register of stage k-1.
    // beat.cin holds the carry handed from the previous slice; sub travels with the beat.
    always_comb begin
        src_vld         = '0;
        src_vld[0]      = in_valid;
        src_beat[0].a   = a;
        src_beat[0].b   = b;
        src_beat[0].sub = sub;
        src_beat[0].cin = sub | cin;
        src_sum[0]      = '0;
        for (int k = 1; k < STAGES; k++) begin
            src_vld[k]  = vld_q[k-1];
            src_beat[k] = beat_q[k-1];
            src_sum[k]  = sum_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            ch_a[k]  = src_beat[k].a[k*CHUNK +: CHUNK];
            ch_b[k]  = src_beat[k].b[k*CHUNK +: CHUNK] ^ {CHUNK{src_beat[k].sub}};
            ch_ci[k] = src_beat[k].cin;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        rca_chunk #(.N(CHUNK)) u_rca (
            .a        (ch_a[k]),
            .b        (ch_b[k]),
            .ci       (ch_ci[k]),
            .s        (ch_s[k]),
            .co       (ch_co[k]),
            .c_msb_in (ch_cmsb[k])
        );
    end

    // Lower result chunks ride along so the full sum leaves the last stage together.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            vld_d[k]                    = src_vld[k];
            sum_d[k]                    = src_sum[k];
            sum_d[k][k*CHUNK +: CHUNK]  = ch_s[k];
            beat_d[k]                   = src_beat[k];
            beat_d[k].cin               = ch_co[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                sum_q[k]  <= '0;
                beat_q[k] <= '0;
            end
        end else if (!stall) begin
            vld_q <= vld_d;
            for (int k = 0; k < STAGES; k++) begin
                sum_q[k]  <= sum_d[k];
                beat_q[k] <= beat_d[k];
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign cout      = beat_q[STAGES-1].cin;

`ifdef ADDER_OVF_FLAG_EN
    logic ovf_q, ovf_d;

    assign ovf_d = ch_cmsb[STAGES-1] ^ ch_co[STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (!stall) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    logic cmsb_unused;
    assign cmsb_unused = ch_cmsb[STAGES-1];
`endif

endmodule

// File: tb/tb_pipe_rca_adder.sv
// Self-checking bench: 8-bit/4-chunk DUT against an arithmetic scoreboard, plus a 4-bit/1-chunk latency check.
module tb_pipe_rca_adder;

    localparam int W8_STAGES = 2;
    localparam int W4_STAGES = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
    logic [7:0] a, b, sum;
    logic       in_valid4, in_ready4, cin4, sub4, out_valid4, out_ready4, cout4;
    logic [3:0] a4, b4, sum4;
`ifdef ADDER_OVF_FLAG_EN
    logic       ovf, ovf4;
`endif

    always #5 clk = ~clk;

    pipe_rca_adder #(.WIDTH(8), .CHUNK(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef ADDER_OVF_FLAG_EN
        , .ovf(ovf)
`endif
    );

    pipe_rca_adder #(.WIDTH(4), .CHUNK(1)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4), .sub(sub4),
        .out_valid(out_valid4), .out_ready(out_ready4), .sum(sum4), .cout(cout4)
`ifdef ADDER_OVF_FLAG_EN
        , .ovf(ovf4)
`endif
    );

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_ret  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Plain integer arithmetic: add is a+b+cin, sub is a-b with cout meaning no borrow.
    function automatic exp_t model(input logic [7:0] ta, input logic [7:0] tb,
                                   input logic tsub, input logic tcin);
        exp_t r;
        int ua = int'(ta);
        int ub = int'(tb);
        int sa = int'($signed(ta));
        int sb = int'($signed(tb));
        int u, s;
        if (tsub) begin
            u      = ua - ub;
            s      = sa - sb;
            r.cout = (ua >= ub);
        end else begin
            u      = ua + ub + int'(tcin);
            s      = sa + sb + int'(tcin);
            r.cout = (u > 255);
        end
        r.sum = u[7:0];
        r.ovf = (s > 127) || (s < -128);
        return r;
    endfunction

    task automatic score();
        exp_t e;
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_sum", 32'(sum), 32'(e.sum));
                    chk("sb_cout", 32'(cout), 32'(e.cout));
`ifdef ADDER_OVF_FLAG_EN
                    chk("sb_ovf", 32'(ovf), 32'(e.ovf));
`endif
                    n_ret++;
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, sub, cin));
        end
    endtask

    // Inputs are driven at the falling edge; scoring happens 1ns later, before the next rising edge.
    task automatic tick();
        #1 score();
        @(negedge clk);
    endtask

    task automatic directed(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                            input logic tsub, input logic tcin,
                            input logic [7:0] esum, input logic ecout, input logic eovf);
        int lat;
        a = ta; b = tb; sub = tsub; cin = tcin; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(W8_STAGES));
        chk({tag, "_sum"}, 32'(sum), 32'(esum));
        chk({tag, "_cout"}, 32'(cout), 32'(ecout));
`ifdef ADDER_OVF_FLAG_EN
        chk({tag, "_ovf"}, 32'(ovf), 32'(eovf));
`else
        if (eovf === 1'bx) $display("note: ovf expectation unknown for %s", tag);
`endif
        tick();
    endtask

    task automatic directed4(input string tag, input logic [3:0] ta, input logic [3:0] tb,
                             input logic tsub, input logic [3:0] esum, input logic ecout);
        int lat;
        a4 = ta; b4 = tb; sub4 = tsub; cin4 = 1'b0; in_valid4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        lat = 1;
        while (!out_valid4 && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(W4_STAGES));
        chk({tag, "_sum"}, 32'(sum4), 32'(esum));
        chk({tag, "_cout"}, 32'(cout4), 32'(ecout));
        tick();
    endtask

    task automatic randomize_beat();
        a   = 8'($urandom);
        b   = 8'($urandom);
        sub = 1'($urandom);
        cin = 1'($urandom);
    endtask

    initial begin
        int n_acc, ret0, guard;
        logic blocked;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0; out_ready4 = 1'b1;
        @(negedge clk);

        // Beats offered during reset must be ignored.
        in_valid = 1'b1; randomize_beat();
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_idle_out_valid", 32'(out_valid), 32'd0);

        directed("add_3c_5a", 8'h3C, 8'h5A, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
        directed("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        directed("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        directed("sub_10_20", 8'h10, 8'h20, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0);
        directed("sub_20_10", 8'h20, 8'h10, 1'b1, 1'b1, 8'h10, 1'b1, 1'b0);
        directed("add_cin", 8'h01, 8'h02, 1'b0, 1'b1, 8'h04, 1'b0, 1'b0);

        directed4("w4_6_a", 4'h6, 4'hA, 1'b0, 4'h0, 1'b1);
        directed4("w4_3_5", 4'h3, 4'h5, 1'b1, 4'hE, 1'b0);

        // Backpressure: with the consumer stalled the pipe fills after STAGES beats.
        out_ready = 1'b0; n_acc = 0; blocked = 1'b0; ret0 = n_ret;
        randomize_beat();
        repeat (8) begin
            in_valid = (n_acc < 3);
            #1;
            if (in_valid && in_ready) n_acc++;
            if (in_valid && !in_ready) blocked = 1'b1;
            if (out_valid && exp_q.size() > 0)
                chk("bp_hold_sum", 32'(sum), 32'(exp_q[0].sum));
            tick();
            if (in_valid && n_acc > 0) randomize_beat();
        end
        chk("bp_in_ready_fell", 32'(blocked), 32'd1);
        chk("bp_accepted_while_full", 32'(n_acc), 32'(W8_STAGES));
        out_ready = 1'b1;
        guard = 0;
        while ((n_acc < 3 || exp_q.size() > 0) && guard < 20) begin
            in_valid = (n_acc < 3);
            #1;
            if (in_valid && in_ready) n_acc++;
            tick();
            guard++;
        end
        in_valid = 1'b0;
        chk("bp_results_out", 32'(n_ret - ret0), 32'd3);

        // Random traffic with random consumer stalls.
        n_acc = 0; ret0 = n_ret; guard = 0;
        while (n_acc < 40 && guard < 400) begin
            randomize_beat();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (in_valid && in_ready) n_acc++;
            tick();
            guard++;
        end
        chk("rand_all_accepted", 32'(n_acc), 32'd40);
        in_valid = 1'b0; out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            tick();
            guard++;
        end
        chk("rand_drain_empty", 32'(exp_q.size()), 32'd0);
        chk("rand_results_out", 32'(n_ret - ret0), 32'(n_acc));

        // Reset with two beats in flight flushes them.
        randomize_beat(); in_valid = 1'b1;
        tick();
        randomize_beat();
        tick();
        in_valid = 1'b0; rst = 1'b1;
        tick();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        exp_q.delete();
        rst = 1'b0;
        repeat (6) begin
            chk("postrst_no_stale", 32'(out_valid), 32'd0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks done %0d", n_chk);
        $fatal(1, "watchdog");
    end

endmodule
